// File: rtl/sm_operand_loader_pkg.sv
// Shared types and constants for the SM operand loader.
package sm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OP1,
    OP2,
    ISSUE,
    HOLD
  } ld_state_e;

  localparam logic [1:0] SM_SEL_RESERVED = 2'b11;
  localparam logic [5:0] SM_SYNC_DEFAULT = 6'b101010;
  localparam int         FRAME_BYTES     = 9;

  // A header is usable only if it carries the sync pattern and a non-reserved select.
  function automatic logic hdr_ok(input logic [7:0] hdr, input logic [5:0] sync);
    return (hdr[7:2] == sync) && (hdr[1:0] != SM_SEL_RESERVED);
  endfunction

endpackage

// File: rtl/sm_operand_loader_if.sv
// Byte-stream input and SM-facing outputs of the operand loader.
interface sm_operand_loader_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        enable;
  logic [1:0]  select;
  logic [31:0] register1;
  logic [31:0] register2;
  logic        frame_err;
  logic        busy;

  modport master (
    output in_valid, in_byte,
    input  in_ready, enable, select, register1, register2, frame_err, busy
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, enable, select, register1, register2, frame_err, busy
  );
endinterface

// File: rtl/sm_operand_loader_shift32.sv
// 32-bit MSB-first byte shift register with synchronous clear and load enable.
module sm_shift32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        ld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] q_o
);
  logic [31:0] sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sh_q <= '0;
    else if (clr_i) sh_q <= '0;
    else if (ld_i)  sh_q <= {sh_q[23:0], byte_i};
  end

  assign q_o = sh_q;
endmodule

// File: rtl/sm_operand_loader.sv
// Assembles 9-byte command frames and issues them to SM with a one-cycle enable.
// Optional idle timeout on partial frames: define SM_LOADER_TIMEOUT_EN.
module sm_operand_loader
  import sm_pkg::*;
#(
  parameter logic [5:0]  SYNC        = SM_SYNC_DEFAULT,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input logic                clock,
  input logic                reset,
  sm_operand_loader_if.slave bus
);

  ld_state_e   state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  sel_sh_q, sel_sh_d;
  logic [15:0] hold_q, hold_d;
  logic        enable_q, enable_d;
  logic        err_q, err_d;
  logic [1:0]  select_q, select_d;
  logic [31:0] r1_q, r1_d;
  logic [31:0] r2_q, r2_d;

  logic        rdy, accept, ld1, ld2, clr;
  logic [31:0] op1_sh, op2_sh;

  // in_ready is forced low while reset is held, even though the state is already IDLE.
  assign rdy    = ~reset & ((state_q == IDLE) | (state_q == OP1) | (state_q == OP2));
  assign accept = bus.in_valid & rdy;

`ifdef SM_LOADER_TIMEOUT_EN
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [IW-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_sh_d = sel_sh_q;
    hold_d   = hold_q;
    enable_d = 1'b0;
    err_d    = 1'b0;
    select_d = select_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    ld1      = 1'b0;
    ld2      = 1'b0;
    clr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hdr_ok(bus.in_byte, SYNC)) begin
            sel_sh_d = bus.in_byte[1:0];
            cnt_d    = 2'd0;
            clr      = 1'b1;
            state_d  = OP1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      OP1: begin
        if (accept) begin
          ld1   = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = OP2;
        end
      end
      OP2: begin
        if (accept) begin
          ld2   = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ISSUE;
        end
      end
      ISSUE: begin
        enable_d = 1'b1;
        select_d = sel_sh_q;
        r1_d     = op1_sh;
        r2_d     = op2_sh;
        if (HOLD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          hold_d  = 16'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == 16'd0) state_d = IDLE;
        else                 hold_d  = hold_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

`ifdef SM_LOADER_TIMEOUT_EN
    // Idle gap counter only runs mid-frame; the case above never moves state without an accept here.
    idle_d = '0;
    if ((state_q == OP1) || (state_q == OP2)) begin
      if (accept) begin
        idle_d = '0;
      end else if (idle_q == IW'(TIMEOUT - 1)) begin
        err_d    = 1'b1;
        clr      = 1'b1;
        sel_sh_d = 2'd0;
        cnt_d    = 2'd0;
        state_d  = IDLE;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_sh_q <= '0;
      hold_q   <= '0;
      enable_q <= 1'b0;
      err_q    <= 1'b0;
      select_q <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_sh_q <= sel_sh_d;
      hold_q   <= hold_d;
      enable_q <= enable_d;
      err_q    <= err_d;
      select_q <= select_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
    end
  end

`ifdef SM_LOADER_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

  sm_shift32 u_op1 (
    .clk    (clock),
    .rst    (reset),
    .clr_i  (clr),
    .ld_i   (ld1),
    .byte_i (bus.in_byte),
    .q_o    (op1_sh)
  );

  sm_shift32 u_op2 (
    .clk    (clock),
    .rst    (reset),
    .clr_i  (clr),
    .ld_i   (ld2),
    .byte_i (bus.in_byte),
    .q_o    (op2_sh)
  );

  assign bus.in_ready  = rdy;
  assign bus.enable    = enable_q;
  assign bus.select    = select_q;
  assign bus.register1 = r1_q;
  assign bus.register2 = r2_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sm_operand_loader.sv
// Directed, table-driven bench for sm_operand_loader (HOLD_CYCLES=2, TIMEOUT=16).
module tb_sm_operand_loader;
  import sm_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sm_operand_loader_if bus();

  sm_operand_loader #(
    .SYNC        (6'b101010),
    .HOLD_CYCLES (2),
    .TIMEOUT     (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests   = 0;
  int fails   = 0;
  int en_cnt  = 0;
  int err_cnt = 0;

  always @(negedge clock) begin
    if (bus.enable)    en_cnt++;
    if (bus.frame_err) err_cnt++;
  end

  typedef struct {
    logic [71:0] frame;
    int          gapmax;
    logic [1:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  localparam int NV = 4;
  vec_t vecs[NV];
  vec_t abort_vec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one byte after an optional idle gap; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   waitc;
    bus.in_valid = 1'b0;
    if (gap > 0) step(gap);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    acc   = 1'b0;
    waitc = 0;
    while (!acc && waitc < 50) begin
      acc = bus.in_ready;
      step();
      waitc++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_wait: byte %h not accepted within 50 cycles", b);
    end
  endtask

  task automatic send_frame(input logic [71:0] f, input int gapmax);
    for (int i = 0; i < FRAME_BYTES; i++)
      send_byte(f[71-8*i -: 8], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int e0;
    e0 = en_cnt;
    send_frame(v.frame, v.gapmax);
    chk($sformatf("v%0d issue_ready", idx), bus.in_ready, 0);
    chk($sformatf("v%0d issue_noen", idx), bus.enable, 0);
    chk($sformatf("v%0d issue_busy", idx), bus.busy, 1);
    step();
    chk($sformatf("v%0d enable", idx), bus.enable, 1);
    chk($sformatf("v%0d select", idx), bus.select, v.sel);
    chk($sformatf("v%0d register1", idx), bus.register1, v.r1);
    chk($sformatf("v%0d register2", idx), bus.register2, v.r2);
    chk($sformatf("v%0d hold1_ready", idx), bus.in_ready, 0);
    step();
    chk($sformatf("v%0d enable_off", idx), bus.enable, 0);
    chk($sformatf("v%0d hold2_ready", idx), bus.in_ready, 0);
    step();
    chk($sformatf("v%0d idle_ready", idx), bus.in_ready, 1);
    chk($sformatf("v%0d idle_busy", idx), bus.busy, 0);
    chk($sformatf("v%0d pulse_count", idx), en_cnt - e0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, bus.in_ready, 0);
    chk({tag, "_enable"}, bus.enable, 0);
    chk({tag, "_select"}, bus.select, 0);
    chk({tag, "_r1"}, bus.register1, 0);
    chk({tag, "_r2"}, bus.register2, 0);
    chk({tag, "_err"}, bus.frame_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, er0;
    vecs[0] = '{72'hA8_00000010_0000000F, 0, 2'd0, 32'h10, 32'h0F};
    vecs[1] = '{72'hA9_0000000F_00000010, 5, 2'd1, 32'h0F, 32'h10};
    vecs[2] = '{72'hAA_12345678_9ABCDEF0, 0, 2'd2, 32'h12345678, 32'h9ABCDEF0};
    vecs[3] = '{72'hA8_FFFFFFFF_80000001, 2, 2'd0, 32'hFFFFFFFF, 32'h80000001};
    abort_vec = '{72'hAA_00000010_0000000F, 0, 2'd2, 32'h10, 32'h0F};

    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    reset        = 1'b1;
    step(2);
    chk_all_zero("rst0");
    reset = 1'b0;
    step();
    chk("rst0_release_ready", bus.in_ready, 1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Rejected headers: bad sync, then reserved select.
    e0  = en_cnt;
    er0 = err_cnt;
    send_byte(8'h55, 0);
    chk("rej55_err", bus.frame_err, 1);
    chk("rej55_busy", bus.busy, 0);
    chk("rej55_ready", bus.in_ready, 1);
    step();
    chk("rej55_err_off", bus.frame_err, 0);
    send_byte(8'hAB, 0);
    chk("rejAB_err", bus.frame_err, 1);
    chk("rejAB_busy", bus.busy, 0);
    step();
    chk("rej_err_pulses", err_cnt - er0, 2);
    chk("rej_no_enable", en_cnt - e0, 0);
    chk("rej_select_kept", bus.select, vecs[NV-1].sel);
    chk("rej_r1_kept", bus.register1, vecs[NV-1].r1);
    chk("rej_r2_kept", bus.register2, vecs[NV-1].r2);
    run_vec(vecs[0], 10);

    // Partial frame, then 16 idle cycles.
    e0  = en_cnt;
    er0 = err_cnt;
    send_byte(8'hA8, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    step(15);
    chk("to_pre_err", bus.frame_err, 0);
    chk("to_pre_busy", bus.busy, 1);
    step();
`ifdef SM_LOADER_TIMEOUT_EN
    chk("to_err", bus.frame_err, 1);
    chk("to_busy", bus.busy, 0);
    chk("to_err_count", err_cnt - er0, 1);
`else
    chk("to_err", bus.frame_err, 0);
    chk("to_busy", bus.busy, 1);
    chk("to_ready", bus.in_ready, 1);
`endif
    chk("to_no_enable", en_cnt - e0, 0);
    chk("to_r1_kept", bus.register1, vecs[0].r1);

    // Mid-simulation reset for 3 cycles.
    reset = 1'b1;
    #1;
    chk_all_zero("rst1");
    step(3);
    chk("rst1_hold_ready", bus.in_ready, 0);
    reset = 1'b0;
    step();
    chk("rst1_release_ready", bus.in_ready, 1);
    chk("rst1_release_busy", bus.busy, 0);

    // Reset after 5 bytes of a frame, then a clean frame.
    e0 = en_cnt;
    send_byte(8'hA8, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    chk("abort_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy_cleared", bus.busy, 0);
    step(3);
    reset = 1'b0;
    step();
    run_vec(abort_vec, 20);
    chk("abort_total_enables", en_cnt - e0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sm_operand_loader.md
# sm_operand_loader

Front-end initiator for the `SM` arithmetic block. It receives a byte stream over a valid/ready handshake and assembles a 9-byte command frame: one header byte, then four bytes each for the two operands. When a frame is complete it drives `select`, `register1` and `register2` into `SM` and pulses `enable` for exactly one cycle. It then holds off new input for a programmable number of cycles while `SM` consumes the operands.

## Interface
- `SYNC` — default 6'b101010 — required value of header bits [7:2].
- `HOLD_CYCLES` — default 2 — cycles `in_ready` stays low after the enable pulse. 0 is legal.
- `TIMEOUT` — default 16 — maximum idle gap, in cycles, allowed between bytes of one frame. Used only with the timeout feature (see Configuration).
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `in_valid` in 1 — `in_byte` holds a valid byte.
- `in_byte` in 8 — stream data.
- `in_ready` out 1 — loader can accept a byte this cycle.
- `enable` out 1 — one-cycle issue strobe to `SM`.
- `select` out 2 — operation code to `SM`.
- `register1` out 32 — operand 1 to `SM`.
- `register2` out 32 — operand 2 to `SM`.
- `frame_err` out 1 — one-cycle pulse when a frame is rejected or aborted.
- `busy` out 1 — high whenever the state is not IDLE.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`. `in_valid` may drop at any time; `in_byte` is ignored when it is not accepted.
- Frame layout:
  - Header: bits [7:2] = `SYNC`, bits [1:0] = select.
  - Operand 1: four bytes, MSB first.
  - Operand 2: four bytes, MSB first.
- States:
  - IDLE: `in_ready`=1. Accepting a valid header latches the shadow select, clears the byte counter, and moves to OP1.
  - OP1: `in_ready`=1. Shifts bytes into shadow operand 1. After the 4th byte, moves to OP2.
  - OP2: `in_ready`=1. Shifts bytes into shadow operand 2. After the 4th byte, moves to ISSUE.
  - ISSUE: `in_ready`=0. Registers `enable`=1 and copies the shadow values to `select`, `register1` and `register2` on the same edge. Moves to HOLD, or to IDLE if `HOLD_CYCLES`=0.
  - HOLD: `in_ready`=0. Counts down `HOLD_CYCLES`, then moves to IDLE.
- Header rejection: a header whose bits [7:2] ≠ `SYNC`, or whose select = 2'b11 (reserved), is consumed and discarded. `frame_err` pulses and the state stays IDLE.
- The `select`, `register1` and `register2` outputs change only on an issue edge. They are stable between issues and during partial frames.
- Reset values: `in_ready`=0 while `reset` is high, then 1 in IDLE. `enable`=0, `select`=0, `register1`=0, `register2`=0, `frame_err`=0, `busy`=0. Shadow registers and counters are cleared.
- Reset asserted mid-frame clears everything immediately. No enable is produced for the partial frame.

## Timing
- `enable` is high for exactly the one cycle following the edge that accepts byte 9. Latency from that accept edge to the `enable` rising edge is one cycle.
- `in_ready` is low for 1 + `HOLD_CYCLES` cycles, starting the cycle after byte 9 is accepted.
- With no gaps in the input, the minimum frame period is 9 + 1 + `HOLD_CYCLES` cycles.
- `frame_err` rises the cycle after the offending edge and lasts one cycle.

## Configuration
- `SM_LOADER_TIMEOUT_EN` defined:
  - In OP1 and OP2, an idle counter resets on each accepted byte.
  - If `TIMEOUT` consecutive cycles pass with no accepted byte, the loader pulses `frame_err`, discards the shadow contents, and returns to IDLE.
  - Outputs are unchanged.
- `SM_LOADER_TIMEOUT_EN` not defined:
  - There is no idle counter. A partial frame waits indefinitely.
  - The `TIMEOUT` parameter is unused.

## Structure
- Package `sm_pkg`:
  - loader state enum: IDLE, OP1, OP2, ISSUE, HOLD.
  - `SM_SEL_RESERVED` = 2'b11.
  - default `SYNC`.
  - `FRAME_BYTES` = 9.
- One sub-module, `sm_shift32`: a 32-bit MSB-first byte shift register with clear and load-enable. It is instantiated twice, once per operand.
- The FSM, hold counter, and timeout counter live in the top level.

## Test plan
- Reset: assert `reset` for 3 cycles mid-simulation → all outputs 0; `in_ready`=1 one cycle after release.
- Continuous stream A8 00 00 00 10 00 00 00 0F → one `enable` pulse the cycle after byte 9, with `select`=0, `register1`=16, `register2`=15; `in_ready` low for 3 cycles.
- Stream A9 00 00 00 0F 00 00 00 10 with random `in_valid` gaps shorter than `TIMEOUT` → `select`=1, `register1`=15, `register2`=16; exactly one `enable` pulse.
- Header 55, then header AB → two `frame_err` pulses, no `enable`, outputs unchanged; a following valid frame A8… issues normally.
- With `SM_LOADER_TIMEOUT_EN`: send A8 00 00 00, then idle for 16 cycles → `frame_err` pulse, return to IDLE, no `enable`. Without the macro, the same stimulus leaves the loader in OP1 with `busy`=1.
- Assert `reset` after 5 bytes of a frame, then send AA 00 00 00 10 00 00 00 0F → `select`=2, `register1`=16, `register2`=15; no enable from the aborted frame.
